// File: rtl/ram_bus_pkg.sv
// Shared types, address constants and byte-merge helper for the RAM bus arbiter.
package ram_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_CAP,
    RMW_ISSUE,
    RMW_WAIT,
    RMW_MERGE,
    ERR,
    DONE
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h1000_1000;
  localparam logic [31:0] DEFAULT_LIMIT_ADDR = 32'h1000_4000;
  localparam logic [31:0] SHOW_IN_DISPLAYS   = 32'h1000_0000;

  // Take each strobed byte from new_word and every other byte from old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, registered history.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant,
  output logic       last_grant
);

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Remember the most recent winner; port 1 at reset so port 0 wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Shares a single-port, 1-cycle-latency RAM between two valid/ready requesters,
// with round-robin arbitration, window decode and read-modify-write byte strobes.
module ram_bus_arbiter
  import ram_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter logic [31:0] LIMIT_ADDR = DEFAULT_LIMIT_ADDR
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              r0_valid,
  input  logic [31:0]       r0_addr,
  input  logic [31:0]       r0_wdata,
  input  logic [3:0]        r0_wstrb,
  output logic              r0_ready,
  output logic [31:0]       r0_rdata,
  input  logic              r1_valid,
  input  logic [31:0]       r1_addr,
  input  logic [31:0]       r1_wdata,
  input  logic [3:0]        r1_wstrb,
  output logic              r1_ready,
  output logic [31:0]       r1_rdata,
  output logic              ram_en,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_data_in,
  input  logic [31:0]       ram_data_out,
  output logic              err
);

  state_t state, next_state;

  logic [1:0]        grant;
  logic              arb_last_grant_unused;
  logic              sel_port;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wstrb;
  logic [31:0]       sel_offset;
  logic [ADDR_W-1:0] sel_word;
  logic              sel_in_window;
  logic              unused_offset_bits;

  logic              lat_port;
  logic [ADDR_W-1:0] lat_word;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_wstrb;

  logic              cur_port;
  logic [ADDR_W-1:0] cur_word;
  logic [31:0]       cur_wdata;
  logic [3:0]        cur_wstrb;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .resetn     (resetn),
    .req        ({r1_valid, r0_valid}),
    .enable     (state == IDLE),
    .grant      (grant),
    .last_grant (arb_last_grant_unused)
  );

  // Select the granted request and decode its address against the RAM window.
  always_comb begin
    sel_port      = grant[1];
    sel_addr      = sel_port ? r1_addr  : r0_addr;
    sel_wdata     = sel_port ? r1_wdata : r0_wdata;
    sel_wstrb     = sel_port ? r1_wstrb : r0_wstrb;
    sel_offset    = sel_addr - BASE_ADDR;
    sel_word      = sel_offset[ADDR_W+1:2];
    sel_in_window = (sel_addr >= BASE_ADDR) && (sel_addr < LIMIT_ADDR);
  end

  assign unused_offset_bits = ^{sel_offset[31:ADDR_W+2], sel_offset[1:0]};

  // In IDLE the live granted request feeds the datapath, afterwards the latched copy.
  always_comb begin
    if (state == IDLE) begin
      cur_port  = sel_port;
      cur_word  = sel_word;
      cur_wdata = sel_wdata;
      cur_wstrb = sel_wstrb;
    end else begin
      cur_port  = lat_port;
      cur_word  = lat_word;
      cur_wdata = lat_wdata;
      cur_wstrb = lat_wstrb;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state decode: one transaction at a time, always finishing through DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (|grant) begin
          if (!sel_in_window)          next_state = ERR;
          else if (sel_wstrb == 4'hF)  next_state = WR;
          else if (sel_wstrb == 4'h0)  next_state = RD_ISSUE;
          else                         next_state = RMW_ISSUE;
        end
      end
      WR:        next_state = DONE;
      RD_ISSUE:  next_state = RD_WAIT;
      RD_WAIT:   next_state = RD_CAP;
      RD_CAP:    next_state = DONE;
      RMW_ISSUE: next_state = RMW_WAIT;
      RMW_WAIT:  next_state = RMW_MERGE;
      RMW_MERGE: next_state = WR;
      ERR:       next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Hold the granted request so the requester may drop valid early.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_port  <= 1'b0;
      lat_word  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else if (state == IDLE && |grant) begin
      lat_port  <= sel_port;
      lat_word  <= sel_word;
      lat_wdata <= sel_wdata;
      lat_wstrb <= sel_wstrb;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_en      <= 1'b0;
      ram_write   <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      r0_ready    <= 1'b0;
      r1_ready    <= 1'b0;
      r0_rdata    <= '0;
      r1_rdata    <= '0;
      err         <= 1'b0;
    end else begin
      ram_en    <= 1'b0;
      ram_write <= 1'b0;
      r0_ready  <= 1'b0;
      r1_ready  <= 1'b0;
      err       <= 1'b0;
      case (next_state)
        WR: begin
          ram_en      <= 1'b1;
          ram_write   <= 1'b1;
          ram_addr    <= cur_word;
          ram_data_in <= (state == RMW_MERGE) ? byte_merge(ram_data_out, cur_wdata, cur_wstrb)
                                              : cur_wdata;
        end
        RD_ISSUE, RMW_ISSUE: begin
          ram_en   <= 1'b1;
          ram_addr <= cur_word;
        end
        ERR: begin
          err <= 1'b1;
          if (cur_port) r1_rdata <= '0;
          else          r0_rdata <= '0;
        end
        DONE: begin
          if (cur_port) r1_ready <= 1'b1;
          else          r0_ready <= 1'b1;
          if (state == RD_CAP) begin
            if (cur_port) r1_rdata <= ram_data_out;
            else          r0_rdata <= ram_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter with a behavioural single-port RAM.
module tb_ram_bus_arbiter;

  localparam logic [31:0] BASE = 32'h1000_1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        r0_valid, r1_valid;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
  logic [3:0]  r0_wstrb, r1_wstrb;
  logic        r0_ready, r1_ready;
  logic [31:0] r0_rdata, r1_rdata;
  logic        ram_en, ram_write;
  logic [13:0] ram_addr;
  logic [31:0] ram_data_in, ram_data_out;
  logic        err;

  typedef struct {
    int          tag;
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_err;
    int          exp_en;
    int          exp_wr;
    logic [31:0] exp_waddr;
  } vec_t;

  typedef struct {
    int          lat;
    int          en_cnt;
    int          wr_cnt;
    int          err_cnt;
    logic [31:0] waddr;
    logic [31:0] rdata;
  } obs_t;

  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[12];
  vec_t        exp_q[$];
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int          order[$];
  logic [31:0] mem [0:16383];

  int          r0c, r1c, enc, r0at, r1at;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.ADDR_W(14), .BASE_ADDR(32'h1000_1000), .LIMIT_ADDR(32'h1000_4000)) dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb),
    .r0_ready(r0_ready), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb),
    .r1_ready(r1_ready), .r1_rdata(r1_rdata),
    .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .err(err)
  );

  // Single-port RAM with a registered read port.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_write) mem[ram_addr] <= ram_data_in;
      else           ram_data_out  <= mem[ram_addr];
    end
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drivePort(input logic p, input logic v, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    if (p) begin
      r1_valid = v; r1_addr = a; r1_wdata = d; r1_wstrb = s;
    end else begin
      r0_valid = v; r0_addr = a; r0_wdata = d; r0_wstrb = s;
    end
  endtask

  function automatic logic getReady(input logic p);
    return p ? r1_ready : r0_ready;
  endfunction

  function automatic logic [31:0] getRdata(input logic p);
    return p ? r1_rdata : r0_rdata;
  endfunction

  function automatic vec_t mkVec(input int tag, input logic p, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s, input logic chk,
                                 input logic [31:0] rd, input int lat, input int e,
                                 input int en, input int wr, input logic [31:0] wa);
    vec_t v;
    v.tag = tag; v.port = p; v.addr = a; v.wdata = d; v.wstrb = s;
    v.chk_rdata = chk; v.exp_rdata = rd; v.exp_lat = lat; v.exp_err = e;
    v.exp_en = en; v.exp_wr = wr; v.exp_waddr = wa;
    return v;
  endfunction

  task automatic checkOutput(input obs_t o);
    vec_t e;
    e = exp_q.pop_front();
    checkValue($sformatf("v%0d_latency", e.tag), o.lat, e.exp_lat);
    checkValue($sformatf("v%0d_err_pulses", e.tag), o.err_cnt, e.exp_err);
    checkValue($sformatf("v%0d_ram_en_cycles", e.tag), o.en_cnt, e.exp_en);
    checkValue($sformatf("v%0d_ram_write_cycles", e.tag), o.wr_cnt, e.exp_wr);
    if (e.exp_wr > 0) checkValue($sformatf("v%0d_write_addr", e.tag), o.waddr, e.exp_waddr);
    if (e.chk_rdata)  checkValue($sformatf("v%0d_rdata", e.tag), o.rdata, e.exp_rdata);
  endtask

  task automatic applyStimulus(input vec_t v);
    obs_t o;
    o = '{lat: 0, en_cnt: 0, wr_cnt: 0, err_cnt: 0, waddr: 32'h0, rdata: 32'h0};
    exp_q.push_back(v);
    drivePort(v.port, 1'b1, v.addr, v.wdata, v.wstrb);
    for (int n = 1; n <= 30; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (ram_en) o.en_cnt++;
      if (ram_write) begin o.wr_cnt++; o.waddr = {18'h0, ram_addr}; end
      if (err) o.err_cnt++;
      if (getReady(v.port)) begin
        o.lat = n;
        o.rdata = getRdata(v.port);
        break;
      end
    end
    drivePort(v.port, 1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput(o);
    @(posedge clk); #1;
  endtask

  task automatic streamPort(input logic p);
    logic got;
    logic [31:0] e;
    for (int i = 0; i < 10; i++) begin
      drivePort(p, 1'b1, BASE + (32'(256 + p * 10 + i) << 2), 32'h0, 4'h0);
      if (p) exp1.push_back(32'hC0DE_0000 + 32'(p * 10 + i));
      else   exp0.push_back(32'hC0DE_0000 + 32'(p * 10 + i));
      got = 1'b0;
      for (int n = 0; n < 60; n++) begin
        @(posedge clk); #1;
        if (getReady(p)) begin got = 1'b1; break; end
      end
      if (!got) begin
        checkValue($sformatf("stream_p%0d_req%0d_ready", p, i), 32'(got), 32'h1);
        break;
      end
      order.push_back(int'(p));
      e = p ? exp1.pop_front() : exp0.pop_front();
      checkValue($sformatf("stream_p%0d_req%0d_rdata", p, i), getRdata(p), e);
    end
    drivePort(p, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = mkVec(0,  0, 32'h1000_1004, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         3, 0, 1, 1, 32'd1);
    vecs[1]  = mkVec(1,  0, 32'h1000_1004, 32'h0,         4'h0, 1, 32'hDEAD_BEEF, 5, 0, 1, 0, 32'd0);
    vecs[2]  = mkVec(2,  0, 32'h1000_1006, 32'h0,         4'h0, 1, 32'hDEAD_BEEF, 5, 0, 1, 0, 32'd0);
    vecs[3]  = mkVec(3,  0, 32'h1000_1008, 32'h1122_3344, 4'hF, 0, 32'h0,         3, 0, 1, 1, 32'd2);
    vecs[4]  = mkVec(4,  0, 32'h1000_1008, 32'hAABB_CCDD, 4'h5, 0, 32'h0,         6, 0, 2, 1, 32'd2);
    vecs[5]  = mkVec(5,  0, 32'h1000_1008, 32'h0,         4'h0, 1, 32'h11BB_33DD, 5, 0, 1, 0, 32'd0);
    vecs[6]  = mkVec(6,  1, 32'h1000_1004, 32'h0,         4'h0, 1, 32'hDEAD_BEEF, 5, 0, 1, 0, 32'd0);
    vecs[7]  = mkVec(7,  1, 32'h1000_4000, 32'h0,         4'h0, 1, 32'h0,         3, 1, 0, 0, 32'd0);
    vecs[8]  = mkVec(8,  1, 32'h1000_0FFC, 32'hFFFF_FFFF, 4'hF, 1, 32'h0,         3, 1, 0, 0, 32'd0);
    vecs[9]  = mkVec(9,  1, 32'h1000_3FFC, 32'h5A5A_A5A5, 4'hF, 0, 32'h0,         3, 0, 1, 1, 32'h0BFF);
    vecs[10] = mkVec(10, 1, 32'h1000_3FFC, 32'h0,         4'h0, 1, 32'h5A5A_A5A5, 5, 0, 1, 0, 32'd0);
    vecs[11] = mkVec(11, 0, 32'h1000_1010, 32'h0102_0304, 4'hF, 0, 32'h0,         3, 0, 1, 1, 32'd4);

    resetn = 1'b0;
    drivePort(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drivePort(1, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_ram_en", 32'(ram_en), 32'h0);
    checkValue("reset_ram_write", 32'(ram_write), 32'h0);
    checkValue("reset_ram_addr", 32'(ram_addr), 32'h0);
    checkValue("reset_ram_data_in", ram_data_in, 32'h0);
    checkValue("reset_r0_ready", 32'(r0_ready), 32'h0);
    checkValue("reset_r1_ready", 32'(r1_ready), 32'h0);
    checkValue("reset_r0_rdata", r0_rdata, 32'h0);
    checkValue("reset_r1_rdata", r1_rdata, 32'h0);
    checkValue("reset_err", 32'(err), 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Reset while a partial write sits in RMW_WAIT.
    applyStimulus(mkVec(12, 0, 32'h1000_1010, 32'h0, 4'h0, 1, 32'h0102_0304, 5, 0, 1, 0, 32'd0));
    drivePort(0, 1'b1, 32'h1000_1010, 32'hFFFF_FFFF, 4'b0011);
    @(posedge clk); #1;
    checkValue("rmw_issue_ram_en", 32'(ram_en), 32'h1);
    @(posedge clk); #1;
    resetn = 1'b0;
    drivePort(0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkValue("midreset_ram_en", 32'(ram_en), 32'h0);
    checkValue("midreset_ram_addr", 32'(ram_addr), 32'h0);
    checkValue("midreset_r0_rdata", r0_rdata, 32'h0);
    checkValue("midreset_r0_ready", 32'(r0_ready), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkValue("midreset_ram_write", 32'(ram_write), 32'h0);
    checkValue("midreset_word_kept", mem[4], 32'h0102_0304);
    resetn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(mkVec(13, 0, 32'h1000_1010, 32'h0, 4'h0, 1, 32'h0102_0304, 5, 0, 1, 0, 32'd0));

    // Words for the contention stream.
    for (int k = 0; k < 20; k++)
      applyStimulus(mkVec(100 + k, 0, BASE + (32'(256 + k) << 2), 32'hC0DE_0000 + 32'(k), 4'hF,
                          0, 32'h0, 3, 0, 1, 1, 32'(256 + k)));

    // Port 0 drops valid after one cycle while port 1 is waiting.
    r0c = 0; r1c = 0; enc = 0; r0at = 0; r1at = 0;
    exp0.push_back(32'hDEAD_BEEF);
    drivePort(0, 1'b1, 32'h1000_1004, 32'h0, 4'h0);
    for (int n = 1; n <= 16; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (n == 2) begin
        drivePort(0, 1'b0, 32'h0, 32'h0, 4'h0);
        exp1.push_back(32'h11BB_33DD);
        drivePort(1, 1'b1, 32'h1000_1008, 32'h0, 4'h0);
      end
      if (ram_en) enc++;
      if (r0_ready) begin
        r0c++; r0at = n;
        if (exp0.size() > 0) checkValue("drop_r0_rdata", r0_rdata, exp0.pop_front());
      end
      if (r1_ready) begin
        r1c++; r1at = n;
        drivePort(1, 1'b0, 32'h0, 32'h0, 4'h0);
        if (exp1.size() > 0) checkValue("drop_r1_rdata", r1_rdata, exp1.pop_front());
      end
    end
    checkValue("drop_r0_ready_count", 32'(r0c), 32'd1);
    checkValue("drop_r1_ready_count", 32'(r1c), 32'd1);
    checkValue("drop_ram_en_count", 32'(enc), 32'd2);
    checkValue("drop_r0_ready_cycle", 32'(r0at), 32'd5);
    checkValue("drop_r1_ready_cycle", 32'(r1at), 32'd10);

    // Both ports requesting back to back.
    exp0.delete();
    exp1.delete();
    fork
      streamPort(1'b0);
      streamPort(1'b1);
    join
    checkValue("stream_total_grants", 32'(order.size()), 32'd20);
    for (int k = 0; k < order.size(); k++)
      checkValue($sformatf("stream_grant_%0d", k), 32'(order[k]), 32'(k % 2));

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
